frac_clk_sched: RTL and testbench
=================================

# frac_clk_sched

Runtime-programmable fractional clock-divider scheduler. Per output period, selects integer divisor D or D+1 with a first-order accumulator, so the average divide ratio is exactly D + NUM/DEN with the long and short periods spread evenly rather than grouped. Drives the output clock directly and accepts new ratios over a valid/ready config port, applying them only at period boundaries. Sits next to the clock-generation logic as the sequencer for the fixed-ratio dividers.

## Interface
- `CW`, default 8: width of the integer divisor D and the period counter.
- `FW`, default 8: width of NUM and DEN.
- `RST_INT`, default 8: D loaded at reset.
- `RST_NUM`, default 7: NUM loaded at reset.
- `RST_DEN`, default 10: DEN loaded at reset, giving an 8.7 average ratio.

Ports (name, direction, width, meaning):
- `clk_in`, in, 1: the single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `en`, in, 1: run enable, sampled at period boundaries.
- `cfg_valid`, in, 1: config request.
- `cfg_ready`, out, 1: config slot free.
- `cfg_int`, in, CW: D.
- `cfg_num`, in, FW: NUM.
- `cfg_den`, in, FW: DEN.
- `cfg_err`, out, 1: one-cycle pulse when a config is rejected.
- `clk_out`, out, 1: divided clock, registered.
- `period_start`, out, 1: one-cycle pulse on the first cycle of each output period.
- `cur_div`, out, CW+1: divisor of the current period; 0 when idle.
- `busy`, out, 1: high while in RUN.

## Operation
- **Reset values:**
  - Active config = RST_INT / RST_NUM / RST_DEN; `acc` = 0.
  - State IDLE; no pending config; `cnt` = 0.
  - `clk_out` = 0, `period_start` = 0, `cur_div` = 0, `busy` = 0, `cfg_err` = 0, `cfg_ready` = 1.
  - Reset mid-period aborts immediately to these values.
- **Config handshake:**
  - A transfer occurs on a cycle with `cfg_valid` & `cfg_ready`.
  - The config is valid iff `cfg_int` ≥ 2, `cfg_den` ≠ 0 and `cfg_num` < `cfg_den`.
  - Invalid config: discarded, `cfg_err` pulses on the next cycle, `cfg_ready` stays 1.
  - Valid config: stored as pending, and `cfg_ready` = 0 from the next cycle until the pending config is applied.
- **Boundary:** a cycle in IDLE, or a cycle in RUN with `cnt` == `cur_div`−1. At the boundary edge:
  - If a config is pending, load it as active, clear `acc` to 0 and clear pending.
  - Then, if `en` = 1:
    - `sum` = `acc` + NUM, computed in FW+1 bits using the active config just loaded.
    - If `sum` ≥ DEN: `div` = D+1 and `acc` = `sum`−DEN. Otherwise `div` = D and `acc` = `sum`.
    - Go to RUN with `cnt` = 0, `cur_div` = `div`, `period_start` = 1.
  - Else go to IDLE with `cur_div` = 0 and `clk_out` = 0.
- **Period counter:** in RUN, `cnt` increments every cycle, and `cur_div` is CW+1 bits wide so that D+1 cannot overflow.
- **Output waveform:** `clk_out` = 1 for period cycles k = 0 .. floor(`div`/2)−1 and 0 for the rest. For example, div 9 gives 4 cycles high and 5 low; div 8 gives 4 high and 4 low.
- **`en` dropped mid-period:** the current period completes and the block idles at the boundary.
- **Config accepted on a boundary cycle:** not applied at that boundary; it is applied at the next boundary (in IDLE, that is the next cycle).

## Timing
- Start-up: with the block in IDLE and `en` = 1 at edge t, after edge t `period_start` = 1, `clk_out` = 1 and `busy` = 1.
- Output periods are back-to-back with no gap cycles: the `period_start` pulses are exactly `cur_div` cycles apart.
- Config latency in IDLE: valid config at edge t becomes pending at t and active at t+1; `cfg_ready` returns to 1 after t+1.
- Config latency in RUN: a pending config takes effect at the first boundary after acceptance, and the next period already uses it.
- `cfg_err` is asserted exactly one cycle after the rejected transfer.

## Structure
- Package `frac_clk_pkg`:
  - State enum {IDLE, RUN}.
  - Reset-default constants.
  - A config struct {int, num, den}.
- Sub-module `frac_acc_step` (combinational): inputs `acc`, NUM, DEN, D; outputs `div` and next `acc`.
- The top level contains the FSM, the pending/active config registers, the handshake, the period counter and the `clk_out` register.

## Test plan
- **Reset defaults, `en` = 1 held:** the first 10 `cur_div` values are 8,9,9,8,9,9,8,9,9,9. Over those 10 periods the block spans exactly 87 cycles and `acc` returns to 0.
- **Waveform shape:** with div 9, `clk_out` is high 4 cycles and low 5; with div 8, high 4 and low 4. `period_start` pulses 9 and 8 cycles apart respectively.
- **Config mid-period:** program D = 5, NUM = 1, DEN = 2 during a div-9 period. The current period finishes at 9 cycles, then the periods run 5,6,5,6. `cfg_ready` is low from acceptance until the boundary.
- **Invalid configs:** `cfg_num` = 3 with `cfg_den` = 3, then `cfg_den` = 0, then `cfg_int` = 1. Each gives a single `cfg_err` pulse, the ratio is unchanged and `cfg_ready` stays 1.
- **Stop/start:** drop `en` at cycle 2 of a period. The period completes, then `cur_div` = 0, `clk_out` = 0 and `busy` = 0. Re-raising `en` gives `period_start` on the next edge.
- **Async reset mid-period:** assert `rst` between clock edges. All outputs take their reset values immediately, without waiting for an edge; the sequence restarts at 8,9,9 after release with `en` = 1.

Source files
------------

// File: rtl/frac_clk_pkg.sv
// Shared types and reset defaults for the fractional clock scheduler.
package frac_clk_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam int DEF_CW  = 8;
    localparam int DEF_FW  = 8;
    localparam int DEF_INT = 8;
    localparam int DEF_NUM = 7;
    localparam int DEF_DEN = 10;

    typedef struct packed {
        logic [DEF_CW-1:0] d;
        logic [DEF_FW-1:0] num;
        logic [DEF_FW-1:0] den;
    } cfg_t;

endpackage

// File: rtl/frac_acc_step.sv
// One first-order accumulator step: pick D or D+1 for the next period.
module frac_acc_step #(
    parameter int CW = 8,
    parameter int FW = 8
) (
    input  logic [FW-1:0] acc_i,
    input  logic [FW-1:0] num_i,
    input  logic [FW-1:0] den_i,
    input  logic [CW-1:0] d_i,
    output logic [CW:0]   div_o,
    output logic [FW-1:0] acc_o
);

    logic [FW:0] sum;

    always_comb begin
        sum   = {1'b0, acc_i} + {1'b0, num_i};
        div_o = {1'b0, d_i};
        acc_o = sum[FW-1:0];
        if (sum >= {1'b0, den_i}) begin
            div_o = {1'b0, d_i} + {{CW{1'b0}}, 1'b1};
            // sum - den < den, so the low FW bits are exact
            acc_o = sum[FW-1:0] - den_i;
        end
    end

endmodule

// File: rtl/frac_clk_sched.sv
// Fractional divider sequencer: D or D+1 per period, averaging D + NUM/DEN.
module frac_clk_sched
    import frac_clk_pkg::*;
#(
    parameter int CW      = DEF_CW,
    parameter int FW      = DEF_FW,
    parameter int RST_INT = DEF_INT,
    parameter int RST_NUM = DEF_NUM,
    parameter int RST_DEN = DEF_DEN
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          en,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_int,
    input  logic [FW-1:0] cfg_num,
    input  logic [FW-1:0] cfg_den,
    output logic          cfg_err,
    output logic          clk_out,
    output logic          period_start,
    output logic [CW:0]   cur_div,
    output logic          busy
);

    typedef struct packed {
        logic [CW-1:0] d;
        logic [FW-1:0] num;
        logic [FW-1:0] den;
    } rcfg_t;

    localparam rcfg_t RST_CFG = '{
        d:   CW'(RST_INT),
        num: FW'(RST_NUM),
        den: FW'(RST_DEN)
    };

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW:0]   div_q, div_d;
    logic [FW-1:0] acc_q, acc_d;
    rcfg_t         act_q, act_d;
    rcfg_t         pend_q, pend_d;
    logic          pvld_q, pvld_d;
    logic          clk_q, clk_d;
    logic          ps_q, ps_d;
    logic          err_q, err_d;

    logic          xfer;
    logic          cfg_ok;
    logic          bnd;
    rcfg_t         src;
    logic [FW-1:0] src_acc;
    logic [CW:0]   step_div;
    logic [FW-1:0] step_acc;
    logic [CW-1:0] cnt_inc;

    assign xfer    = cfg_valid & ~pvld_q;
    assign cfg_ok  = (cfg_int >= CW'(2)) && (cfg_den != '0)
                     && (cfg_num < cfg_den);
    assign bnd     = (state_q == IDLE)
                     || ({1'b0, cnt_q} == div_q - {{CW{1'b0}}, 1'b1});
    // A pending config is applied at this boundary with a fresh accumulator
    assign src     = pvld_q ? pend_q : act_q;
    assign src_acc = pvld_q ? '0 : acc_q;
    assign cnt_inc = cnt_q + {{(CW-1){1'b0}}, 1'b1};

    frac_acc_step #(
        .CW (CW),
        .FW (FW)
    ) u_step (
        .acc_i (src_acc),
        .num_i (src.num),
        .den_i (src.den),
        .d_i   (src.d),
        .div_o (step_div),
        .acc_o (step_acc)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        acc_d   = acc_q;
        act_d   = act_q;
        pend_d  = pend_q;
        pvld_d  = pvld_q;
        clk_d   = clk_q;
        ps_d    = 1'b0;
        err_d   = 1'b0;

        if (xfer) begin
            if (cfg_ok) begin
                pend_d = '{d: cfg_int, num: cfg_num, den: cfg_den};
                pvld_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        if (bnd) begin
            if (pvld_q) begin
                act_d  = pend_q;
                acc_d  = '0;
                pvld_d = 1'b0;
            end
            cnt_d = '0;
            if (en) begin
                state_d = RUN;
                div_d   = step_div;
                acc_d   = step_acc;
                ps_d    = 1'b1;
                clk_d   = |step_div[CW:1];
            end else begin
                state_d = IDLE;
                div_d   = '0;
                clk_d   = 1'b0;
            end
        end else begin
            cnt_d = cnt_inc;
            clk_d = cnt_inc < div_q[CW:1];
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            acc_q   <= '0;
            act_q   <= RST_CFG;
            pend_q  <= '0;
            pvld_q  <= 1'b0;
            clk_q   <= 1'b0;
            ps_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            acc_q   <= acc_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            pvld_q  <= pvld_d;
            clk_q   <= clk_d;
            ps_q    <= ps_d;
            err_q   <= err_d;
        end
    end

    assign cfg_ready    = ~pvld_q;
    assign cfg_err      = err_q;
    assign clk_out      = clk_q;
    assign period_start = ps_q;
    assign cur_div      = div_q;
    assign busy         = (state_q == RUN);

endmodule

// File: tb/tb_frac_clk_sched.sv
// Directed bench for frac_clk_sched with hand-computed period sequences.
module tb_frac_clk_sched;
    import frac_clk_pkg::*;

    logic       clk_in = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_int = '0;
    logic [7:0] cfg_num = '0;
    logic [7:0] cfg_den = '0;
    logic       cfg_ready;
    logic       cfg_err;
    logic       clk_out;
    logic       period_start;
    logic [8:0] cur_div;
    logic       busy;

    int n_chk = 0;
    int n_pass = 0;

    int   exp_div[10] = '{8, 9, 9, 8, 9, 9, 8, 9, 9, 9};
    int   exp_new[4]  = '{5, 6, 5, 6};
    cfg_t bad[3] = '{
        '{8'd4, 8'd3, 8'd3},
        '{8'd4, 8'd0, 8'd0},
        '{8'd1, 8'd1, 8'd2}
    };

    always #5 clk_in = ~clk_in;

    frac_clk_sched dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_int      (cfg_int),
        .cfg_num      (cfg_num),
        .cfg_den      (cfg_den),
        .cfg_err      (cfg_err),
        .clk_out      (clk_out),
        .period_start (period_start),
        .cur_div      (cur_div),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic wait_ps();
        int n = 0;
        while (!period_start && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        check("wait_ps", period_start, 1);
    endtask

    // Called at the negedge showing period_start; returns at the next one
    // (or at the first idle cycle when en was dropped).
    task automatic measure(input int inj_at, input int drop_at,
                           output int div, output int len,
                           output int hi, output bit rdy_lo);
        div = int'(cur_div);
        len = 0;
        hi = 0;
        rdy_lo = 1'b1;
        do begin
            if (len == inj_at) cfg_valid = 1'b1;
            if (inj_at >= 0 && len == inj_at + 1) cfg_valid = 1'b0;
            if (inj_at >= 0 && len > inj_at && cfg_ready) rdy_lo = 1'b0;
            if (len == drop_at) en = 1'b0;
            if (clk_out) hi++;
            len++;
            @(negedge clk_in);
        end while (!period_start && busy && len < 300);
    endtask

    task automatic send_cfg(input cfg_t c, output logic e1,
                            output logic e2, output logic r);
        cfg_int = c.d;
        cfg_num = c.num;
        cfg_den = c.den;
        cfg_valid = 1'b1;
        @(negedge clk_in);
        cfg_valid = 1'b0;
        e1 = cfg_err;
        r = cfg_ready;
        @(negedge clk_in);
        e2 = cfg_err;
    endtask

    initial begin
        int d, l, h, tot, d1, d2;
        bit rl;
        logic e1, e2, r;

        #1 rst = 1'b1;
        repeat (2) @(negedge clk_in);
        check("rst_clk", clk_out, 0);
        check("rst_ps", period_start, 0);
        check("rst_div", cur_div, 0);
        check("rst_busy", busy, 0);
        check("rst_err", cfg_err, 0);
        check("rst_rdy", cfg_ready, 1);

        rst = 1'b0;
        en = 1'b1;
        @(negedge clk_in);
        check("start_ps", period_start, 1);
        check("start_clk", clk_out, 1);
        check("start_busy", busy, 1);

        tot = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) check("acc_zero", dut.acc_q, 0);
            measure(-1, -1, d, l, h, rl);
            check("seq_div", d, exp_div[i]);
            check("seq_len", l, exp_div[i]);
            check("seq_hi", h, exp_div[i] / 2);
            tot += l;
        end
        check("span87", tot, 87);

        measure(-1, -1, d, l, h, rl);
        check("p11_div", d, 8);

        cfg_int = 8'd5;
        cfg_num = 8'd1;
        cfg_den = 8'd2;
        measure(2, -1, d, l, h, rl);
        check("mid_div", d, 9);
        check("mid_len", l, 9);
        check("mid_hi", h, 4);
        check("mid_rdy_lo", rl, 1);
        check("mid_rdy_back", cfg_ready, 1);
        for (int i = 0; i < 4; i++) begin
            measure(-1, -1, d, l, h, rl);
            check("new_div", d, exp_new[i]);
            check("new_len", l, exp_new[i]);
            check("new_hi", h, exp_new[i] / 2);
        end

        for (int i = 0; i < 3; i++) begin
            send_cfg(bad[i], e1, e2, r);
            check("bad_err1", e1, 1);
            check("bad_err2", e2, 0);
            check("bad_rdy", r, 1);
        end
        wait_ps();
        measure(-1, -1, d1, l, h, rl);
        measure(-1, -1, d2, l, h, rl);
        check("bad_sum", d1 + d2, 11);
        check("bad_alt", d1 != d2, 1);

        measure(-1, 2, d, l, h, rl);
        check("stop_div", d, d1);
        check("stop_len", l, d1);
        check("stop_hi", h, d1 / 2);
        check("stop_curdiv", cur_div, 0);
        check("stop_clk", clk_out, 0);
        check("stop_busy", busy, 0);
        repeat (2) @(negedge clk_in);
        check("idle_busy", busy, 0);
        check("idle_ps", period_start, 0);
        en = 1'b1;
        @(negedge clk_in);
        check("restart_ps", period_start, 1);
        check("restart_div", cur_div, d2);

        @(negedge clk_in);
        check("pre_rst_clk", clk_out, 1);
        #3 rst = 1'b1;
        #1;
        check("arst_clk", clk_out, 0);
        check("arst_div", cur_div, 0);
        check("arst_busy", busy, 0);
        check("arst_ps", period_start, 0);
        check("arst_rdy", cfg_ready, 1);
        check("arst_err", cfg_err, 0);
        @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);
        check("rel_ps", period_start, 1);
        for (int i = 0; i < 3; i++) begin
            measure(-1, -1, d, l, h, rl);
            check("rel_div", d, exp_div[i]);
            check("rel_len", l, exp_div[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
